// File: rtl/shift_xfer_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shift_xfer_ctrl_pkg
// Shared definitions for the shift-register transfer controller.
//   - xfer_state_e : controller FSM states
//   - MODE_*       : datapath mode encoding (parallel-in/serial-out vs
//                    serial-in/parallel-out)
//   - DIR_*        : datapath shift direction encoding
//   - DEFAULT_WIDTH: default datapath width
// ---------------------------------------------------------------------------
package shift_xfer_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic MODE_PISO = 1'b0;
  localparam logic MODE_SIPO = 1'b1;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    FINISH = 3'd3,
    HOLD   = 3'd4
  } xfer_state_e;

endpackage

// File: rtl/shift_xfer_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// xfer_rr_arb2
// Two-way round-robin arbiter between a transmit and a receive requester.
// When both request together, the side that was not granted last wins.
// The last-grant flag comes out of reset pointing at RX, so TX wins the
// first contested arbitration.
//
// Ports
//   clk, rst  : clock, asynchronous active-high reset
//   req_tx    : transmit request
//   req_rx    : receive request
//   en        : arbitration enable (grants only issued while high)
//   gnt_tx    : transmit grant (combinational)
//   gnt_rx    : receive grant (combinational)
//   last_tx   : last-grant flag, 1 = TX was granted most recently
// ---------------------------------------------------------------------------
module xfer_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_tx,
  input  logic req_rx,
  input  logic en,
  output logic gnt_tx,
  output logic gnt_rx,
  output logic last_tx
);

  logic lastTx_q;
  logic lastTx_d;

  // A side loses a contested request only if it was the one served last.
  assign gnt_tx = en & req_tx & (~req_rx | ~lastTx_q);
  assign gnt_rx = en & req_rx & (~req_tx |  lastTx_q);

  assign last_tx = lastTx_q;

  // The flag only moves when a grant is actually issued.
  always_comb begin
    lastTx_d = lastTx_q;
    if (gnt_tx) begin
      lastTx_d = 1'b1;
    end else if (gnt_rx) begin
      lastTx_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastTx_q <= 1'b0;
    end else begin
      lastTx_q <= lastTx_d;
    end
  end

endmodule

// File: rtl/shift_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// shift_xfer_ctrl
// Controller for an external shift-register datapath. Serialises a word
// (PISO transmit) or collects a word (SIPO receive), one transfer at a time,
// with round-robin arbitration between the two request sides.
//
// Sequence per transfer: IDLE -> LOAD (1 cycle, ld) -> SHIFT (WIDTH cycles,
// shft_en) -> FINISH -> IDLE for transmit, or FINISH -> HOLD -> IDLE for
// receive, where HOLD presents rx_data until the consumer takes it.
//
// Ports
//   clk, rst     : clock, asynchronous active-high reset
//   tx_valid     : transmit request, word on tx_data, direction on tx_dir
//   tx_ready     : controller can accept a transmit request
//   tx_done      : one-cycle pulse in FINISH of a transmit
//   rx_valid_in  : receive request, direction on rx_dir
//   rx_ack       : one-cycle pulse after a receive request is accepted
//   rx_valid     : received word presented on rx_data (HOLD)
//   rx_ready     : consumer takes rx_data
//   sr_q         : current datapath shift-register contents
//   ld, ld_data  : datapath parallel load strobe and value
//   shft_en      : datapath shift enable
//   mode, dir    : datapath mode (0 PISO, 1 SIPO) and direction (0 right)
//   busy         : controller is not in IDLE
// ---------------------------------------------------------------------------
module shift_xfer_ctrl
  import shift_xfer_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_dir,
  output logic             tx_done,
  input  logic             rx_valid_in,
  output logic             rx_ack,
  input  logic             rx_dir,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  input  logic [WIDTH-1:0] sr_q,
  output logic             ld,
  output logic [WIDTH-1:0] ld_data,
  output logic             shft_en,
  output logic             mode,
  output logic             dir,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  xfer_state_e      state_q,  state_d;
  logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
  logic             mode_q,   mode_d;
  logic             dir_q,    dir_d;
  logic [WIDTH-1:0] ldData_q, ldData_d;
  logic [WIDTH-1:0] rxData_q, rxData_d;
  logic             rxAck_q,  rxAck_d;

  logic gntTx;
  logic gntRx;
  logic lastTx;
  logic isIdle;

  assign isIdle = (state_q == IDLE);

  xfer_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_tx  (tx_valid),
    .req_rx  (rx_valid_in),
    .en      (isIdle),
    .gnt_tx  (gntTx),
    .gnt_rx  (gntRx),
    .last_tx (lastTx)
  );

  // Next-state logic. Transfer parameters (data, direction, mode) are
  // captured only on acceptance so later input changes cannot disturb a
  // transfer in flight. rx_ack is registered, so it shows up alongside
  // the LOAD cycle rather than combinationally in IDLE.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    mode_d   = mode_q;
    dir_d    = dir_q;
    ldData_d = ldData_q;
    rxData_d = rxData_q;
    rxAck_d  = 1'b0;

    case (state_q)
      IDLE: begin
        bitCnt_d = '0;
        if (gntTx) begin
          ldData_d = tx_data;
          dir_d    = tx_dir ? DIR_LEFT : DIR_RIGHT;
          mode_d   = MODE_PISO;
          state_d  = LOAD;
        end else if (gntRx) begin
          ldData_d = '0;
          dir_d    = rx_dir ? DIR_LEFT : DIR_RIGHT;
          mode_d   = MODE_SIPO;
          rxAck_d  = 1'b1;
          state_d  = LOAD;
        end
      end

      LOAD: begin
        bitCnt_d = '0;
        state_d  = SHIFT;
      end

      // bitCnt_q counts shifts already issued; the WIDTH-th shift is the
      // one issued while the count reads WIDTH-1.
      SHIFT: begin
        if (bitCnt_q == CNT_W'(WIDTH - 1)) begin
          bitCnt_d = '0;
          state_d  = FINISH;
        end else begin
          bitCnt_d = bitCnt_q + CNT_W'(1);
        end
      end

      // The last shift has landed in sr_q by now, so a receive captures it.
      FINISH: begin
        if (mode_q == MODE_SIPO) begin
          rxData_d = sr_q;
          state_d  = HOLD;
        end else begin
          state_d  = IDLE;
        end
      end

      HOLD: begin
        if (rx_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      mode_q   <= MODE_PISO;
      dir_q    <= DIR_RIGHT;
      ldData_q <= '0;
      rxData_q <= '0;
      rxAck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      mode_q   <= mode_d;
      dir_q    <= dir_d;
      ldData_q <= ldData_d;
      rxData_q <= rxData_d;
      rxAck_q  <= rxAck_d;
    end
  end

  // Strobes are pure state decodes; only tx_ready looks at an input, so a
  // transmitter sees immediately when a pending receive will win.
  assign ld       = (state_q == LOAD);
  assign shft_en  = (state_q == SHIFT);
  assign tx_done  = (state_q == FINISH) && (mode_q == MODE_PISO);
  assign rx_valid = (state_q == HOLD);
  assign busy     = !isIdle;
  assign rx_ack   = rxAck_q;
  assign mode     = mode_q;
  assign dir      = dir_q;
  assign ld_data  = ldData_q;
  assign rx_data  = rxData_q;
  assign tx_ready = isIdle && !(rx_valid_in && lastTx);

endmodule

// File: tb/tb_shift_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_xfer_ctrl
// Scoreboard bench for shift_xfer_ctrl. A 4-bit instance is driven with
// directed transfers and backed by a small shift-register datapath model;
// an 8-bit instance runs one transmit. Stimulus pushes expected events
// (with the cycle they must appear in) onto a queue; the monitor pops and
// compares whenever the DUT raises an output strobe.
// ---------------------------------------------------------------------------
module tb_shift_xfer_ctrl;

  localparam int EV_ACK    = 1;
  localparam int EV_LD     = 2;
  localparam int EV_SHIFT  = 3;
  localparam int EV_DONE   = 4;
  localparam int EV_RXV    = 5;
  localparam int EV8_LD    = 12;
  localparam int EV8_SHIFT = 13;
  localparam int EV8_DONE  = 14;

  typedef struct {
    int          kind;
    logic [17:0] value;
    int          cyc;
  } ev_t;

  typedef struct {
    int   cyc;
    logic val;
  } rdy_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 4-bit instance signals
  logic       tx_valid, tx_ready, tx_dir, tx_done;
  logic [3:0] tx_data;
  logic       rx_valid_in, rx_ack, rx_dir, rx_valid, rx_ready;
  logic [3:0] rx_data, sr_q, ld_data;
  logic       ld, shft_en, mode, dir, busy;

  // 8-bit instance signals
  logic       tx_valid8, tx_ready8, tx_dir8, tx_done8;
  logic [7:0] tx_data8, rx_data8, ld_data8;
  logic       rx_ack8, rx_valid8;
  logic       ld8, shft_en8, mode8, dir8, busy8;

  shift_xfer_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_dir(tx_dir), .tx_done(tx_done),
    .rx_valid_in(rx_valid_in), .rx_ack(rx_ack), .rx_dir(rx_dir),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .sr_q(sr_q), .ld(ld), .ld_data(ld_data), .shft_en(shft_en),
    .mode(mode), .dir(dir), .busy(busy)
  );

  shift_xfer_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid8), .tx_ready(tx_ready8), .tx_data(tx_data8),
    .tx_dir(tx_dir8), .tx_done(tx_done8),
    .rx_valid_in(1'b0), .rx_ack(rx_ack8), .rx_dir(1'b0),
    .rx_valid(rx_valid8), .rx_ready(1'b1), .rx_data(rx_data8),
    .sr_q(8'h00), .ld(ld8), .ld_data(ld_data8), .shft_en(shft_en8),
    .mode(mode8), .dir(dir8), .busy(busy8)
  );

  // Datapath model for the 4-bit instance: loads on ld, shifts on shft_en
  // in the mode/direction the controller selects, feeding seStream bits in
  // for receives.
  logic [3:0] dpSr;
  logic [1:0] shIdx;
  logic [0:3] seStream;
  logic       seOut;
  logic       seIn;

  assign sr_q  = dpSr;
  assign seOut = dir ? dpSr[3] : dpSr[0];
  assign seIn  = seStream[shIdx];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      dpSr  <= 4'b0000;
      shIdx <= 2'd0;
    end else if (ld) begin
      dpSr  <= ld_data;
      shIdx <= 2'd0;
    end else if (shft_en) begin
      shIdx <= shIdx + 2'd1;
      if (!mode) dpSr <= dir ? {dpSr[2:0], 1'b0} : {1'b0, dpSr[3:1]};
      else       dpSr <= dir ? {dpSr[2:0], seIn} : {seIn, dpSr[3:1]};
    end
  end

  // Scoreboard state
  ev_t  expQ[$];
  rdy_t rdyQ[$];
  int   testsRun    = 0;
  int   testsFailed = 0;
  int   drainReq    = 0;
  int   drainSeen   = 0;

  function automatic void pushEv(int k, logic [17:0] v, int c);
    ev_t e;
    e.kind  = k;
    e.value = v;
    e.cyc   = c;
    expQ.push_back(e);
  endfunction

  function automatic void pushReady(int c, logic v);
    rdy_t r;
    r.cyc = c;
    r.val = v;
    rdyQ.push_back(r);
  endfunction

  // Transmit accepted at cycle t: ld at t+1, shifts t+2..t+5 with the given
  // serial bits, tx_done at t+6.
  function automatic void pushTx(int t, logic [3:0] d, logic dr, logic [0:3] bits);
    pushEv(EV_LD, {1'b0, dr, 12'b0, d}, t + 1);
    for (int i = 0; i < 4; i++) pushEv(EV_SHIFT, {1'b0, dr, 15'b0, bits[i]}, t + 2 + i);
    pushEv(EV_DONE, 18'b0, t + 6);
  endfunction

  // Receive accepted at cycle t: rx_ack and zero load at t+1, shifts
  // t+2..t+5, FINISH t+6, rx_valid from t+7 for holdCycles cycles.
  function automatic void pushRx(int t, logic dr, logic [3:0] data, int holdCycles);
    pushEv(EV_ACK, 18'b0, t + 1);
    pushEv(EV_LD, {1'b1, dr, 16'b0}, t + 1);
    for (int i = 0; i < 4; i++) pushEv(EV_SHIFT, {1'b1, dr, 16'b0}, t + 2 + i);
    for (int h = 0; h < holdCycles; h++) pushEv(EV_RXV, {14'b0, data}, t + 7 + h);
  endfunction

  task automatic checkVal(string name, logic [63:0] act, logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  task automatic observe(string name, int k, logic [17:0] v);
    ev_t e;
    testsRun++;
    if (expQ.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got unexpected event value %h, required no event",
               name, cyc, v);
    end else begin
      e = expQ.pop_front();
      if (e.kind != k || e.value !== v || e.cyc != cyc) begin
        testsFailed++;
        $display("[TB] FAIL %s: got kind %0d value %h at cycle %0d, required kind %0d value %h at cycle %0d",
                 name, k, v, cyc, e.kind, e.value, e.cyc);
      end
    end
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin : monitor
    rdy_t r;
    if (rst) begin
      checkVal("reset_ctrl4", {ld, shft_en, mode, dir, tx_done, rx_ack, rx_valid, busy,
                               ld_data, rx_data}, 64'd0);
      checkVal("reset_ctrl8", {ld8, shft_en8, mode8, dir8, tx_done8, rx_ack8, rx_valid8, busy8,
                               ld_data8, rx_data8}, 64'd0);
    end else begin
      checkVal("ld_shft_exclusive", {63'd0, ld & shft_en}, 64'd0);
      if (rx_ack)   observe("rx_ack",   EV_ACK,   18'b0);
      if (ld)       observe("ld",       EV_LD,    {mode, dir, 12'b0, ld_data});
      if (shft_en)  observe("shift",    EV_SHIFT, {mode, dir, 15'b0, (mode ? 1'b0 : seOut)});
      if (tx_done)  observe("tx_done",  EV_DONE,  18'b0);
      if (rx_valid) observe("rx_valid", EV_RXV,   {14'b0, rx_data});
      if (ld8)      observe("w8_ld",    EV8_LD,   {10'b0, ld_data8});
      if (shft_en8) observe("w8_shift", EV8_SHIFT, {mode8, dir8, 16'b0});
      if (tx_done8) observe("w8_done",  EV8_DONE, 18'b0);
      while (rdyQ.size() > 0 && rdyQ[0].cyc <= cyc) begin
        r = rdyQ.pop_front();
        if (r.cyc != cyc) checkVal("tx_ready_missed", 64'(r.cyc), 64'(cyc));
        else              checkVal("tx_ready", {63'd0, tx_ready}, {63'd0, r.val});
      end
      if (drainReq != drainSeen) begin
        drainSeen = drainReq;
        checkVal("queue_drained", 64'(expQ.size()), 64'd0);
      end
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    while (busy || busy8) begin
      nextCycle();
      n++;
      if (n > 100) begin
        $display("[TB] FAIL wait_idle: busy %b/%b after 100 cycles, required 0/0", busy, busy8);
        $fatal(1, "[TB] controller stuck");
      end
    end
  endtask

  task automatic drain();
    drainReq++;
    nextCycle();
    nextCycle();
  endtask

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] timeout");
  end

  // Stimulus
  initial begin : applyStimulus
    int t;
    tx_valid    = 1'b0; tx_data  = 4'b0000; tx_dir = 1'b0;
    rx_valid_in = 1'b0; rx_dir   = 1'b0;    rx_ready = 1'b1;
    tx_valid8   = 1'b0; tx_data8 = 8'h00;   tx_dir8 = 1'b0;
    seStream    = 4'b0000;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Both requests straight out of reset: TX wins, RX follows.
    t = cyc;
    tx_valid = 1'b1; tx_data = 4'b0101; tx_dir = 1'b1;
    rx_valid_in = 1'b1; rx_dir = 1'b0;
    pushReady(t, 1'b1);
    pushTx(t, 4'b0101, 1'b1, 4'b0101);
    pushReady(t + 7, 1'b0);
    pushRx(t + 7, 1'b0, 4'b0000, 1);
    nextCycle();
    tx_valid = 1'b0;
    while (cyc < t + 8) nextCycle();
    rx_valid_in = 1'b0;
    waitIdle();
    drain();

    // Both held continuously: grants alternate TX, RX, TX.
    t = cyc;
    tx_valid = 1'b1; tx_data = 4'b1100; tx_dir = 1'b0;
    rx_valid_in = 1'b1; rx_dir = 1'b1;
    pushReady(t, 1'b1);
    pushTx(t, 4'b1100, 1'b0, 4'b0011);
    pushReady(t + 7, 1'b0);
    pushRx(t + 7, 1'b1, 4'b0000, 1);
    pushReady(t + 15, 1'b1);
    pushTx(t + 15, 4'b1100, 1'b0, 4'b0011);
    while (cyc < t + 16) nextCycle();
    tx_valid = 1'b0;
    rx_valid_in = 1'b0;
    waitIdle();
    drain();

    // TX right of 1011: serial out 1,1,0,1. Inputs change after acceptance.
    t = cyc;
    tx_valid = 1'b1; tx_data = 4'b1011; tx_dir = 1'b0;
    pushReady(t, 1'b1);
    pushTx(t, 4'b1011, 1'b0, 4'b1101);
    nextCycle();
    tx_valid = 1'b0; tx_data = 4'b0000; tx_dir = 1'b1;
    waitIdle();
    drain();

    // RX left-in of stream 1,0,0,1 gives 1001; rx_ready already high.
    seStream = 4'b1001;
    t = cyc;
    rx_valid_in = 1'b1; rx_dir = 1'b1;
    pushRx(t, 1'b1, 4'b1001, 1);
    nextCycle();
    rx_valid_in = 1'b0; rx_dir = 1'b0;
    waitIdle();
    drain();

    // RX right-in of stream 1,1,0,1 gives 1011; 5 cycles of backpressure
    // while a transmit waits, then the transmit (0011, MSB first) runs.
    seStream = 4'b1101;
    rx_ready = 1'b0;
    t = cyc;
    rx_valid_in = 1'b1; rx_dir = 1'b0;
    pushRx(t, 1'b0, 4'b1011, 6);
    for (int c = 8; c <= 12; c++) pushReady(t + c, 1'b0);
    pushReady(t + 13, 1'b1);
    pushTx(t + 13, 4'b0011, 1'b1, 4'b0011);
    nextCycle();
    rx_valid_in = 1'b0;
    while (cyc < t + 8) nextCycle();
    tx_valid = 1'b1; tx_data = 4'b0011; tx_dir = 1'b1;
    while (cyc < t + 12) nextCycle();
    rx_ready = 1'b1;
    while (cyc < t + 14) nextCycle();
    tx_valid = 1'b0;
    waitIdle();
    drain();

    // Reset during the second shift of a TX: no further strobes, no tx_done.
    t = cyc;
    tx_valid = 1'b1; tx_data = 4'b1110; tx_dir = 1'b0;
    pushReady(t, 1'b1);
    pushEv(EV_LD, {2'b00, 12'b0, 4'b1110}, t + 1);
    pushEv(EV_SHIFT, 18'b0, t + 2);
    nextCycle();
    tx_valid = 1'b0;
    nextCycle();
    nextCycle();
    #1;
    rst = 1'b1;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    repeat (3) nextCycle();
    drain();

    // Following TX of 0110 completes normally.
    t = cyc;
    tx_valid = 1'b1; tx_data = 4'b0110; tx_dir = 1'b0;
    pushReady(t, 1'b1);
    pushTx(t, 4'b0110, 1'b0, 4'b0110);
    nextCycle();
    tx_valid = 1'b0;
    waitIdle();
    drain();

    // WIDTH=8 TX: ld at t+1, exactly 8 shifts t+2..t+9, tx_done at t+10.
    t = cyc;
    tx_valid8 = 1'b1; tx_data8 = 8'hA5; tx_dir8 = 1'b0;
    pushEv(EV8_LD, {10'b0, 8'hA5}, t + 1);
    for (int i = 0; i < 8; i++) pushEv(EV8_SHIFT, 18'b0, t + 2 + i);
    pushEv(EV8_DONE, 18'b0, t + 10);
    nextCycle();
    tx_valid8 = 1'b0;
    waitIdle();
    drain();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/shift_xfer_ctrl.md
SHIFT_XFER_CTRL -- requirements
Module: shift_xfer_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: datapath shift-register width in bits, legal range 2..16.
REQ-002 clk  in  1  clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 tx_valid  in  1  transmit request (PISO), data on tx_data.
REQ-005 tx_ready  out  1  controller can accept a transmit request.
REQ-006 tx_data  in  WIDTH  word to serialise.
REQ-007 tx_dir  in  1  transmit shift direction; 0 = right (LSB first), 1 = left (MSB first).
REQ-008 tx_done  out  1  one-cycle pulse when the transmit finishes.
REQ-009 rx_valid_in  in  1  receive request (SIPO).
REQ-010 rx_ack  out  1  one-cycle pulse when the receive request is accepted.
REQ-011 rx_dir  in  1  receive shift direction; 0 = right-in, 1 = left-in.
REQ-012 rx_valid  out  1  received word available on rx_data.
REQ-013 rx_ready  in  1  consumer accepts rx_data.
REQ-014 rx_data  out  WIDTH  received word.
REQ-015 sr_q  in  WIDTH  current shift-register contents from the datapath.
REQ-016 ld  out  1  datapath parallel-load strobe.
REQ-017 ld_data  out  WIDTH  datapath parallel-load value.
REQ-018 shft_en  out  1  datapath shift enable.
REQ-019 mode  out  1  datapath mode; 0 = PISO, 1 = SIPO.
REQ-020 dir  out  1  datapath direction; 0 = right, 1 = left.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 FSM states SHALL be IDLE, LOAD, SHIFT, FINISH and HOLD.
REQ-023 In IDLE with tx_valid=1 and a TX grant, the controller SHALL latch tx_data and tx_dir, set mode=0, and go to LOAD.
REQ-024 In IDLE with rx_valid_in=1 and an RX grant, it SHALL pulse rx_ack, latch rx_dir, set mode=1, and go to LOAD.
REQ-025 Arbitration SHALL be two-way round-robin.
  - When both requests are present, grant the side not granted last.
  - The last-grant flag resets to RX, so TX wins first.
REQ-026 tx_ready SHALL equal (state==IDLE) AND NOT (rx_valid_in AND last-grant==TX).
REQ-027 LOAD SHALL last exactly one cycle with ld=1.
  - ld_data = latched tx_data for TX; all zeros for RX.
REQ-028 SHIFT SHALL assert shft_en for exactly WIDTH consecutive cycles, counted by a bit counter of width clog2(WIDTH+1).
REQ-029 mode and dir SHALL stay constant from LOAD through FINISH; ld and shft_en SHALL never be high together.
REQ-030 TX latency: accept at cycle T; LOAD at T+1; shifts at T+2..T+1+WIDTH; FINISH with tx_done=1 at T+2+WIDTH; IDLE at T+3+WIDTH.
REQ-031 RX FINISH SHALL register sr_q into rx_data, then enter HOLD.
REQ-032 HOLD SHALL assert rx_valid and keep rx_data stable.
  - Return to IDLE on the cycle rx_ready=1.
  - If rx_ready is already high on HOLD entry, HOLD lasts one cycle.
REQ-033 Requests arriving outside IDLE SHALL be ignored until IDLE; requests are never queued.
REQ-034 Changes to tx_data, tx_dir or rx_dir after acceptance SHALL NOT affect the transfer in flight.
REQ-035 ld, shft_en, tx_done, rx_ack, rx_valid and busy SHALL be decoded from registered state, with no combinational path from inputs.
REQ-036 Exception: tx_ready may depend combinationally on rx_valid_in.

Reset
REQ-037 rst SHALL force state IDLE, bit counter 0 and last-grant RX.
REQ-038 rst SHALL force ld, shft_en, mode, dir, tx_done, rx_ack, rx_valid and busy to 0, and ld_data and rx_data to all zeros.
REQ-039 Reset mid-transfer SHALL abort without completion pulses; the first request after deassertion follows REQ-023/024.

Structure
REQ-040 A shared package SHALL hold the FSM state enum, the MODE_PISO/MODE_SIPO and DIR_RIGHT/DIR_LEFT constants, and the default WIDTH.
REQ-041 The round-robin arbiter SHALL be one sub-module, xfer_rr_arb2 (inputs req_tx, req_rx, en; outputs gnt_tx, gnt_rx).

Verification
REQ-042 TX right: tx_data=4'b1011, tx_dir=0, accept at T.
  - Expect ld at T+1 with ld_data=1011; shft_en at T+2..T+5 with mode=0, dir=0; tx_done at T+6.
  - Datapath se_out sequence must be 1,1,0,1.
REQ-043 RX left: rx_dir=1, datapath se_in stream 1,0,0,1, rx_ready=1.
  - Expect rx_ack, then ld with ld_data=0000, then 4 shifts.
  - rx_valid for one cycle with rx_data=4'b1001.
REQ-044 Simultaneous tx_valid and rx_valid_in out of reset: TX served first, RX second.
  - Repeat with both requests held: grants alternate TX, RX, TX.
REQ-045 RX backpressure: rx_ready=0 for 5 cycles in HOLD.
  - rx_valid stays high and rx_data stable; tx_valid is ignored (tx_ready=0) until rx_ready=1 returns the FSM to IDLE.
REQ-046 rst asserted during shift 2 of a TX: all outputs 0 asynchronously, no tx_done.
  - A following TX of 4'b0110 completes normally.
REQ-047 WIDTH=8 TX: exactly 8 shft_en cycles, and tx_done at T+10.
